// File: rtl/rr_arbiter_8_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
// The master side drives enable and requests; the slave (the arbiter) returns
// the registered grant, its encoded index, and the GS/EO-style status flags.
interface rr_arbiter_8_if;
  logic       en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_vld;
  logic       idle;

  modport master (
    output en,
    output req,
    input  gnt,
    input  gnt_idx,
    input  gnt_vld,
    input  idle
  );

  modport slave (
    input  en,
    input  req,
    output gnt,
    output gnt_idx,
    output gnt_vld,
    output idle
  );
endinterface

// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with a bounded hold time and a global enable.
// Grants are registered and one-hot; gnt_idx is the encoded winner and holds
// its last value while nothing is granted. On every release the priority
// pointer moves to the slot after the outgoing owner, and a new winner is
// picked in the same cycle so back-to-back grants have no gap.
module rr_arbiter_8 #(
  parameter int MAX_HOLD = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  rr_arbiter_8_if.slave bus
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Last hold_cnt value a grant may reach before it is forced to release.
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] gnt_idx_q, gnt_idx_d;
  logic       gnt_vld_q, gnt_vld_d;

  logic       any_req;
  logic       release_c;
  logic [2:0] next_ptr;
  logic [2:0] winner;

  // First set request scanning upward from p with wrap-around.
  function automatic logic [2:0] arb(input logic [7:0] r, input logic [2:0] p);
    logic [2:0] w;
    logic [2:0] i;
    logic       found;
    w     = p;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      i = p + 3'(k);
      if (!found && r[i]) begin
        w     = i;
        found = 1'b1;
      end
    end
    return w;
  endfunction

  assign any_req  = |bus.req;
  assign next_ptr = gnt_idx_q + 3'd1;

  // Release conditions for the current owner, and the winner of the next
  // arbitration (starting after the owner on release, at ptr from idle).
  always_comb begin
    release_c = 1'b0;
    winner    = arb(bus.req, ptr_q);
    if (state_q == ST_GRANT) begin
      release_c = !bus.en || !bus.req[gnt_idx_q] || (hold_cnt_q == HOLD_LAST);
      winner    = arb(bus.req, next_ptr);
    end
  end

  // Next-state: grant, hold, hand over, or drop back to idle.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    gnt_d      = gnt_q;
    gnt_idx_d  = gnt_idx_q;
    gnt_vld_d  = gnt_vld_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.en && any_req) begin
          state_d    = ST_GRANT;
          gnt_d      = 8'b1 << winner;
          gnt_idx_d  = winner;
          gnt_vld_d  = 1'b1;
          hold_cnt_d = 8'd0;
        end else begin
          gnt_d     = 8'd0;
          gnt_vld_d = 1'b0;
        end
      end
      ST_GRANT: begin
        if (release_c) begin
          ptr_d = next_ptr;
          if (bus.en && any_req) begin
            gnt_d      = 8'b1 << winner;
            gnt_idx_d  = winner;
            gnt_vld_d  = 1'b1;
            hold_cnt_d = 8'd0;
          end else begin
            state_d   = ST_IDLE;
            gnt_d     = 8'd0;
            gnt_vld_d = 1'b0;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        gnt_d     = 8'd0;
        gnt_vld_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset clears everything, even mid-grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= 3'd0;
      hold_cnt_q <= 8'd0;
      gnt_q      <= 8'd0;
      gnt_idx_q  <= 3'd0;
      gnt_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q      <= gnt_d;
      gnt_idx_q  <= gnt_idx_d;
      gnt_vld_q  <= gnt_vld_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_idx = gnt_idx_q;
  assign bus.gnt_vld = gnt_vld_q;
  assign bus.idle    = bus.en & ~any_req & ~gnt_vld_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Testbench for rr_arbiter_8 (MAX_HOLD=4): directed scenarios followed by a
// random phase, checked against a behavioural reference through a queue.
module tb_rr_arbiter_8;

  localparam int MAXH = 4;

  logic clk;
  logic rst_n;

  rr_arbiter_8_if bus ();

  rr_arbiter_8 #(.MAX_HOLD(MAXH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       vld;
    logic [2:0] ptr;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state
  bit m_busy;
  int m_owner;
  int m_cnt;
  int m_ptr;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [7:0] r, input int start);
    for (int k = 0; k < 8; k++) begin
      if (r[(start + k) % 8]) return (start + k) % 8;
    end
    return -1;
  endfunction

  task automatic model_step(input logic rn, input logic e, input logic [7:0] r);
    bit rel;
    if (!rn) begin
      m_busy = 0; m_owner = 0; m_cnt = 0; m_ptr = 0;
    end else if (!m_busy) begin
      if (e && r != 8'd0) begin
        m_owner = pick(r, m_ptr);
        m_busy  = 1;
        m_cnt   = 0;
      end
    end else begin
      rel = !e || !r[m_owner] || (m_cnt == MAXH - 1);
      if (rel) begin
        m_ptr = (m_owner + 1) % 8;
        if (e && r != 8'd0) begin
          m_owner = pick(r, m_ptr);
          m_cnt   = 0;
        end else begin
          m_busy = 0;
        end
      end else begin
        m_cnt++;
      end
    end
  endtask

  // Drive one cycle of stimulus, predict, then compare after the edge.
  task automatic cyc(input logic rn, input logic e, input logic [7:0] r);
    exp_t x;
    exp_t y;
    logic exp_idle;
    rst_n   = rn;
    bus.en  = e;
    bus.req = r;
    model_step(rn, e, r);
    x.gnt = m_busy ? (8'b1 << m_owner) : 8'd0;
    x.idx = 3'(m_owner);
    x.vld = m_busy;
    x.ptr = 3'(m_ptr);
    sb_q.push_back(x);
    @(posedge clk);
    #1;
    y = sb_q.pop_front();
    exp_idle = e & ~(|r) & ~y.vld;
    check("gnt",     32'(bus.gnt),       32'(y.gnt));
    check("gnt_idx", 32'(bus.gnt_idx),   32'(y.idx));
    check("gnt_vld", 32'(bus.gnt_vld),   32'(y.vld));
    check("idle",    32'(bus.idle),      32'(exp_idle));
    check("ptr",     32'(dut.ptr_q),     32'(y.ptr));
  endtask

  int s1_idx[16] = '{3, 3, 3, 3, 6, 6, 6, 6, 7, 7, 7, 7, 3, 3, 3, 3};

  initial begin
    logic       rn;
    logic       e;
    logic [7:0] r;
    rst_n   = 1'b0;
    bus.en  = 1'b0;
    bus.req = 8'd0;
    m_busy = 0; m_owner = 0; m_cnt = 0; m_ptr = 0;

    // Reset
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 8'hC8);

    // Scenario 1: rotation among 3, 6, 7 with no gaps
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 1'b1, 8'hC8);
      check("s1_idx", 32'(bus.gnt_idx), 32'(s1_idx[i]));
      check("s1_vld", 32'(bus.gnt_vld), 32'd1);
    end

    // Scenario 2: owner drops request early
    cyc(1'b0, 1'b1, 8'h00);
    cyc(1'b1, 1'b1, 8'h64);
    cyc(1'b1, 1'b1, 8'h64);
    cyc(1'b1, 1'b1, 8'h60);
    check("s2_handover", 32'(bus.gnt_idx), 32'd5);
    for (int i = 0; i < 9; i++) cyc(1'b1, 1'b1, 8'h64);

    // Scenario 3: enable removed during a grant to 5, then wrap to 1
    cyc(1'b0, 1'b1, 8'h00);
    cyc(1'b1, 1'b1, 8'h20);
    cyc(1'b1, 1'b1, 8'h20);
    cyc(1'b1, 1'b0, 8'h20);
    check("s3_revoked", 32'(bus.gnt), 32'd0);
    cyc(1'b1, 1'b1, 8'h32);
    check("s3_wrap", 32'(bus.gnt_idx), 32'd1);
    cyc(1'b1, 1'b1, 8'h32);

    // Scenario 4: lone requester 7 stays granted across timeouts
    cyc(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 14; i++) cyc(1'b1, 1'b1, 8'h80);

    // Scenario 5: reset in the middle of a grant
    cyc(1'b1, 1'b1, 8'h08);
    cyc(1'b1, 1'b1, 8'h08);
    cyc(1'b0, 1'b1, 8'h08);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 8'h08);

    // Scenario 6: idle flag and a single-cycle request pulse
    cyc(1'b1, 1'b1, 8'h00);
    cyc(1'b1, 1'b1, 8'h00);
    cyc(1'b1, 1'b1, 8'h01);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 8'h00);

    // Random phase
    r = 8'h00;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) r = 8'($urandom());
      e  = ($urandom_range(0, 15) != 0);
      rn = ($urandom_range(0, 63) != 0);
      cyc(rn, e, r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_8.md
# rr_arbiter_8

Round-robin arbiter that shares one resource among eight requesters. It turns a raw 8-bit request vector into a registered one-hot grant plus its 3-bit encoded index. The outputs mirror the 8-3 encoder's status flags: `gnt_vld` works like GS and `idle` works like EO. It sits in front of any shared datapath slot that the encoder-style select logic currently feeds. It adds fairness, a bounded hold time, and a global enable.

## Interface
Parameters:
- `MAX_HOLD`, default 4: maximum consecutive cycles one grant may last. Legal range 1..255.

Ports:
- `clk`, input, 1: sole clock. All state updates on its rising edge.
- `rst_n`, input, 1: synchronous, active-low reset.
- `en`, input, 1: arbiter enable (EI analogue). When 0, no new grants are issued and any current grant is revoked.
- `req`, input, 8: request vector. Bit i high means requester i wants the resource.
- `gnt`, output, 8: registered one-hot grant. All zeros when nothing is granted.
- `gnt_idx`, output, 3: registered binary index of the granted bit. Holds its last value when `gnt_vld`=0.
- `gnt_vld`, output, 1: registered. High exactly when `gnt` is non-zero (GS analogue).
- `idle`, output, 1: combinational, `en & ~|req & ~gnt_vld` (EO analogue).

## Operation
- Internal state:
  - `state` is IDLE or GRANT.
  - `ptr` is 3 bits, the highest-priority index for the next arbitration.
  - `hold_cnt` is 8 bits, the cycles elapsed in the current grant (0 on the first grant cycle).
- Arbitration function `arb(req, p)`: the first set bit of `req`, scanning p, p+1, … 7, 0, … p−1 (mod 8).
- IDLE:
  - If `en`=1 and `req`≠0: winner w = arb(req, ptr). Next cycle: `gnt`=1<<w, `gnt_idx`=w, `gnt_vld`=1, `hold_cnt`=0, state GRANT.
  - Otherwise remain in IDLE with outputs at 0.
- GRANT, with owner o: the grant is released when any of the following holds:
  - (a) `en`=0;
  - (b) `req[o]`=0;
  - (c) `hold_cnt`=MAX_HOLD−1.
  If none holds, `hold_cnt` increments and the grant is unchanged.
- On release:
  - `ptr` ← o+1 (mod 8). 7 wraps to 0.
  - If `en`=1 and `req`≠0: re-arbitrate in the same cycle with w = arb(req, o+1). The next cycle grants w, with `hold_cnt`=0 and no gap cycle. The owner o competes last, and only if `req[o]` is still 1 (the case (c) timeout).
  - Otherwise: next cycle `gnt`=0, `gnt_vld`=0, state IDLE.
- A lone requester that is still requesting after a timeout is re-granted. `gnt` stays continuously asserted and `hold_cnt` restarts at 0.
- `ptr` changes only on release. An IDLE→GRANT transition does not move it.
- `req` changing on non-owner bits during GRANT has no effect until release.

## Timing
- Reset (`rst_n`=0 at a clock edge), values from the next cycle:
  - `gnt`=0, `gnt_idx`=0, `gnt_vld`=0.
  - `ptr`=0, `hold_cnt`=0, state IDLE.
  - `idle` then follows its equation.
- Reset overrides everything, including a grant that is in progress.
- Request-to-grant latency is 1 cycle. `req` sampled at edge k gives `gnt` valid after edge k.
- Release latency is 1 cycle. A release condition sampled at edge k changes `gnt` after edge k.
- Maximum grant length is MAX_HOLD cycles. With MAX_HOLD=1, every grant lasts exactly 1 cycle and priority rotates every cycle.
- Simultaneous events:
  - `en`=0 and `req[o]`=0 together: a single release; `ptr`=o+1.
  - `en` returning to 1 is evaluated at the same edge as IDLE arbitration.
- Worst-case wait for a continuously requesting input is 7·MAX_HOLD cycles.

## Test plan
All scenarios use MAX_HOLD=4 unless stated otherwise.

1. Reset, then `en`=1, `req`=8'hC8:
   - Requester 3 holds `gnt`=8'h08, `gnt_idx`=3 for 4 cycles.
   - Then 6 for 4 cycles (`gnt`=8'h40), then 7 (8'h80), then 3 again.
   - `gnt_vld` stays 1 throughout, with no gap cycles.
2. `req`=8'h64, grant goes to 2. Drop `req[2]` after 2 grant cycles:
   - The next cycle grants 5 (`gnt_idx`=5).
   - Then 6; then 2 again if `req[2]` has been restored.
3. During a grant to 5, drive `en`=0:
   - `gnt`=0 and `gnt_vld`=0 next cycle; `idle`=0.
   - Restore `en`=1 with `req`=8'h32: the grant goes to 1 (arb from `ptr`=6 wraps 6,7,0,1).
4. `req`=8'h80 only:
   - Grant 7 is continuous for 12 cycles.
   - Internally `ptr`=0 after each timeout (wrap from 7).
   - `gnt` never drops.
5. Reset asserted mid-grant with `req`=8'h08:
   - All outputs are 0 the next cycle.
   - After release of `rst_n`, requester 3 is granted one cycle later with `ptr` starting at 0.
6. `en`=1, `req`=0:
   - `idle`=1 and `gnt_vld`=0.
   - Pulse `req`=8'h01 for exactly 1 cycle: a 1-cycle grant to 0, then release (`req[0]`=0), then IDLE with `idle`=1.
